majority_sweep_checker: RTL and testbench
=========================================

# majority_sweep_checker

Synthesizable on-board counterpart to the five-input majority bench. It sweeps all 32 switch codes (0 to 31) into a majority-vote DUT and samples the DUT's single-bit response at a fixed point in each dwell window. Each response is compared against a built-in golden model, and the block reports the mismatch count, the first failing code, and pass/fail on LEDs. It sits between the board top level and the majority DUT, replacing the manual switch inputs during self-test.

## Interface
- DWELL, default 4: clock cycles each code is held on `dut_in`; legal range ≥ 1.
- SETTLE, default 2: cycle index within the dwell window at which `dut_resp` is sampled; legal range 0 ≤ SETTLE < DWELL, checked at elaboration.
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  reset; asynchronous and active-low.
- start  in  1  level; sampled on each rising edge; starts a sweep when in IDLE or DONE.
- dut_in  out  5  code driven to the DUT, bit order ABCDE (bit 4 = A).
- dut_resp  in  1  DUT majority output; synchronous to clk or held stable for at least SETTLE cycles.
- busy  out  1  high while a sweep is in progress.
- done  out  1  high in DONE; held until the next start.
- pass  out  1  equals done && err_count == 0.
- err_count  out  6  number of mismatches in the last sweep, range 0 to 32.
- first_fail  out  5  lowest code that mismatched.
- first_fail_valid  out  1  high once at least one mismatch has been recorded.

## Operation
- FSM states: IDLE → RUN → DONE.
  - IDLE → RUN when start = 1.
  - DONE → RUN when start = 1.
  - RUN → DONE after the last cycle of code 31.
  - No other transitions exist.
- Entering RUN:
  - `dut_in`, the dwell counter `dcnt`, err_count, first_fail and first_fail_valid all clear to 0.
  - busy = 1, done = 0.
- In RUN, `dcnt` counts from 0 to DWELL−1. On the edge where `dcnt == SETTLE`:
  - expected = (popcount(dut_in) ≥ 3);
  - if dut_resp ≠ expected, err_count increments;
  - if that is the first mismatch, first_fail ← dut_in and first_fail_valid ← 1.
- At `dcnt == DWELL−1`:
  - `dcnt` wraps to 0;
  - if `dut_in` < 31, `dut_in` increments;
  - if `dut_in` = 31, the FSM goes to DONE. `dut_in` holds at 31 and does not wrap to 0.
- start while in RUN is ignored; a sweep cannot be restarted mid-run.
- start held high continuously: the block runs a new sweep each time it re-enters DONE, giving back-to-back sweeps.
- err_count cannot overflow, since the maximum is 32 and 6 bits hold it; no saturation logic is needed.
- Reset asserted at any time, including mid-sweep:
  - all outputs return to reset values immediately;
  - FSM goes to IDLE;
  - no partial results are retained.

## Timing
- Reset values: dut_in = 0, busy = 0, done = 0, pass = 0, err_count = 0, first_fail = 0, first_fail_valid = 0, FSM = IDLE.
- Edge E0 samples start = 1. From E0 onward, busy = 1 and code 0 is on `dut_in`.
- Code k is driven during cycles E0 + k·DWELL through E0 + (k+1)·DWELL − 1.
- dut_resp for code k is sampled at edge E0 + k·DWELL + SETTLE + 1. This gives the DUT SETTLE full cycles of settling time.
- done = 1 and busy = 0 from edge E0 + 32·DWELL onward. Total sweep latency is 32·DWELL cycles.
- err_count and first_fail update on the sample edge and are visible the following cycle.
- Boundary case DWELL = 1, SETTLE = 0: one code per cycle, sample on every edge; the sweep completes in 32 cycles.

## Structure
- Shared package `majority_pkg`:
  - `N_IN` = 5 and `N_CODES` = 32;
  - state enum {IDLE, RUN, DONE};
  - function `majority_ref(logic [4:0])` returning popcount ≥ 3. The DUT bench reuses this function.
- One sub-module, `dwell_timer`:
  - parameterized by DWELL and SETTLE;
  - outputs `sample_pulse` and `window_end`.
- FSM, code counter and result registers stay in the top module.

## Test plan
- Correct majority DUT, default parameters, start pulse → done at E0 + 128, err_count = 0, pass = 1, first_fail_valid = 0.
- DUT stuck-at-0 → err_count = 16, first_fail = 7 (00111), pass = 0.
- DUT stuck-at-1 → err_count = 16, first_fail = 0, first_fail_valid = 1.
- Inverted DUT with DWELL = 1, SETTLE = 0 → err_count = 32, done after exactly 32 cycles.
- Start re-pulsed at code 12 → ignored, sweep completes normally. rst_n low at code 10 → all outputs go to reset values at once. Fresh start afterwards → full correct sweep with err_count = 0.
- DUT response delayed one cycle, SETTLE = 0 → mismatches reported. Same DUT with SETTLE = 2 → err_count = 0.

Source files
------------

// File: rtl/majority_pkg.sv
// Shared definitions for the five-input majority self-test: sizes, sweep states
// and the golden majority function reused by the DUT bench.
package majority_pkg;

   localparam int N_IN    = 5;
   localparam int N_CODES = 32;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   function automatic logic majority_ref(input logic [N_IN-1:0] code);
      int ones;
      ones = 0;
      for (int i = 0; i < N_IN; i++) begin
         ones += int'(code[i]);
      end
      return (ones >= 3);
   endfunction

endpackage

// File: rtl/dwell_timer.sv
// Dwell-window counter: marks the sample point and the last cycle of each
// code's hold window while the sweep is running.
module dwell_timer #(
   parameter int DWELL  = 4,
   parameter int SETTLE = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   output logic sample_pulse,
   output logic window_end
);

   localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CW-1:0] LAST_CNT   = CW'(DWELL - 1);
   localparam logic [CW-1:0] SAMPLE_CNT = CW'(SETTLE);

   if (DWELL < 1 || SETTLE < 0 || SETTLE >= DWELL) begin : g_param_check
      $error("dwell_timer: SETTLE must satisfy 0 <= SETTLE < DWELL");
   end

   logic [CW-1:0] dcnt;

   // Held at zero outside a sweep so every new sweep starts a fresh window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dcnt <= '0;
      end else if (!enable || dcnt == LAST_CNT) begin
         dcnt <= '0;
      end else begin
         dcnt <= dcnt + 1'b1;
      end
   end

   assign sample_pulse = enable && (dcnt == SAMPLE_CNT);
   assign window_end   = enable && (dcnt == LAST_CNT);

endmodule

// File: rtl/majority_sweep_checker.sv
// On-board self-test: sweeps all 32 codes into the majority DUT, compares each
// sampled response with the golden model and reports the results.
module majority_sweep_checker
   import majority_pkg::*;
#(
   parameter int DWELL  = 4,
   parameter int SETTLE = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic [4:0] dut_in,
   input  logic       dut_resp,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [5:0] err_count,
   output logic [4:0] first_fail,
   output logic       first_fail_valid
);

   state_t state, state_next;
   logic   running, sample_pulse, window_end, last_code, start_sweep;

   assign running     = (state == RUN);
   assign last_code   = (dut_in == 5'(N_CODES - 1));
   assign start_sweep = start && !running;

   dwell_timer #(
      .DWELL (DWELL),
      .SETTLE(SETTLE)
   ) u_timer (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (running),
      .sample_pulse(sample_pulse),
      .window_end  (window_end)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Start is only honoured outside RUN, so a sweep can never be restarted mid-run.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (window_end && last_code) state_next = DONE;
         DONE:    if (start) state_next = RUN;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
      pass = done && (err_count == 6'd0);
   end

   // Code counter and result registers; the code holds at 31 when the sweep ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dut_in           <= '0;
         err_count        <= '0;
         first_fail       <= '0;
         first_fail_valid <= 1'b0;
      end else if (start_sweep) begin
         dut_in           <= '0;
         err_count        <= '0;
         first_fail       <= '0;
         first_fail_valid <= 1'b0;
      end else if (running) begin
         if (sample_pulse && (dut_resp != majority_ref(dut_in))) begin
            err_count <= err_count + 6'd1;
            if (!first_fail_valid) begin
               first_fail       <= dut_in;
               first_fail_valid <= 1'b1;
            end
         end
         if (window_end && !last_code) begin
            dut_in <= dut_in + 5'd1;
         end
      end
   end

endmodule

// File: tb/tb_majority_sweep_checker.sv
// Directed self-checking bench: three checker instances (4/2, 1/0, 4/0) each
// driving a behavioural majority DUT whose fault mode is selected per step.
module tb_majority_sweep_checker;

   logic clk, rst_n;
   int   checks, failures;

   logic       start_main, start_fast, start_s0;
   logic       resp_main, resp_fast, resp_s0;
   logic       dly_main, dly_fast, dly_s0;
   int         mode_main, mode_fast, mode_s0;
   logic [4:0] in_main, in_fast, in_s0;
   logic       busy_main, busy_fast, busy_s0;
   logic       done_main, done_fast, done_s0;
   logic       pass_main, pass_fast, pass_s0;
   logic [5:0] err_main, err_fast, err_s0;
   logic [4:0] ff_main, ff_fast, ff_s0;
   logic       ffv_main, ffv_fast, ffv_s0;

   majority_sweep_checker #(.DWELL(4), .SETTLE(2)) u_main (
      .clk(clk), .rst_n(rst_n), .start(start_main), .dut_in(in_main), .dut_resp(resp_main),
      .busy(busy_main), .done(done_main), .pass(pass_main), .err_count(err_main),
      .first_fail(ff_main), .first_fail_valid(ffv_main));

   majority_sweep_checker #(.DWELL(1), .SETTLE(0)) u_fast (
      .clk(clk), .rst_n(rst_n), .start(start_fast), .dut_in(in_fast), .dut_resp(resp_fast),
      .busy(busy_fast), .done(done_fast), .pass(pass_fast), .err_count(err_fast),
      .first_fail(ff_fast), .first_fail_valid(ffv_fast));

   majority_sweep_checker #(.DWELL(4), .SETTLE(0)) u_s0 (
      .clk(clk), .rst_n(rst_n), .start(start_s0), .dut_in(in_s0), .dut_resp(resp_s0),
      .busy(busy_s0), .done(done_s0), .pass(pass_s0), .err_count(err_s0),
      .first_fail(ff_s0), .first_fail_valid(ffv_s0));

   always #5 clk = ~clk;

   function automatic logic tbMaj(input logic [4:0] code);
      return ($countones(code) >= 3);
   endfunction

   // Modes: 0 correct, 1 stuck-at-0, 2 stuck-at-1, 3 inverted, 4 one-cycle delayed.
   function automatic logic modelResp(input int mode, input logic [4:0] code, input logic dly);
      case (mode)
         1:       return 1'b0;
         2:       return 1'b1;
         3:       return ~tbMaj(code);
         4:       return dly;
         default: return tbMaj(code);
      endcase
   endfunction

   always @(posedge clk) begin
      dly_main <= tbMaj(in_main);
      dly_fast <= tbMaj(in_fast);
      dly_s0   <= tbMaj(in_s0);
   end

   always_comb begin
      resp_main = modelResp(mode_main, in_main, dly_main);
      resp_fast = modelResp(mode_fast, in_fast, dly_fast);
      resp_s0   = modelResp(mode_s0, in_s0, dly_s0);
   end

   // Field select: 0 dut_in, 1 busy, 2 done, 3 pass, 4 err_count, 5 first_fail, 6 first_fail_valid.
   function automatic logic [31:0] obs(input int which, input int field);
      logic [4:0] din, ff;
      logic       bsy, dn, ps, ffv;
      logic [5:0] err;
      case (which)
         1:       begin din = in_fast; bsy = busy_fast; dn = done_fast; ps = pass_fast; err = err_fast; ff = ff_fast; ffv = ffv_fast; end
         2:       begin din = in_s0;   bsy = busy_s0;   dn = done_s0;   ps = pass_s0;   err = err_s0;   ff = ff_s0;   ffv = ffv_s0;   end
         default: begin din = in_main; bsy = busy_main; dn = done_main; ps = pass_main; err = err_main; ff = ff_main; ffv = ffv_main; end
      endcase
      case (field)
         0:       return 32'(din);
         1:       return 32'(bsy);
         2:       return 32'(dn);
         3:       return 32'(ps);
         4:       return 32'(err);
         5:       return 32'(ff);
         default: return 32'(ffv);
      endcase
   endfunction

   task automatic setStart(input int which, input logic val);
      case (which)
         1:       start_fast = val;
         2:       start_s0   = val;
         default: start_main = val;
      endcase
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Pulses start, optionally re-pulses it when pokeCode is on dut_in, and
   // counts edges after E0 until done rises (bounded).
   task automatic applyStimulus(input int which, input int pokeCode, output int cycles);
      bit poked;
      poked = 0;
      @(negedge clk);
      setStart(which, 1'b1);
      @(posedge clk);
      #1;
      setStart(which, 1'b0);
      checkOutput("busy_after_E0", obs(which, 1), 1);
      checkOutput("code0_after_E0", obs(which, 0), 0);
      checkOutput("done_low_after_E0", obs(which, 2), 0);
      cycles = 0;
      while (cycles < 2000 && obs(which, 2) == 0) begin
         @(posedge clk);
         cycles++;
         #1;
         setStart(which, 1'b0);
         if (pokeCode >= 0 && !poked && obs(which, 0) == 32'(pokeCode)) begin
            setStart(which, 1'b1);
            poked = 1;
         end
      end
      checkOutput("done_reached", obs(which, 2), 1);
      checkOutput("busy_low_in_done", obs(which, 1), 0);
   endtask

   initial begin
      int cyc;
      int exp_delay_errs;
      logic [4:0] prev;

      clk = 0; rst_n = 0; checks = 0; failures = 0;
      start_main = 0; start_fast = 0; start_s0 = 0;
      mode_main = 0; mode_fast = 0; mode_s0 = 0;

      repeat (3) @(negedge clk);
      checkOutput("rst_dut_in", obs(0, 0), 0);
      checkOutput("rst_busy", obs(0, 1), 0);
      checkOutput("rst_done", obs(0, 2), 0);
      checkOutput("rst_pass", obs(0, 3), 0);
      checkOutput("rst_err", obs(0, 4), 0);
      checkOutput("rst_ff", obs(0, 5), 0);
      checkOutput("rst_ffv", obs(0, 6), 0);
      @(negedge clk);
      rst_n = 1;

      $display("[TB] correct DUT, DWELL=4 SETTLE=2");
      mode_main = 0;
      applyStimulus(0, -1, cyc);
      checkOutput("ok_latency", 32'(cyc), 128);
      checkOutput("ok_err", obs(0, 4), 0);
      checkOutput("ok_pass", obs(0, 3), 1);
      checkOutput("ok_ffv", obs(0, 6), 0);
      checkOutput("ok_code_holds_31", obs(0, 0), 31);

      $display("[TB] stuck-at-0 DUT");
      mode_main = 1;
      applyStimulus(0, -1, cyc);
      checkOutput("s0_err", obs(0, 4), 16);
      checkOutput("s0_ff", obs(0, 5), 7);
      checkOutput("s0_ffv", obs(0, 6), 1);
      checkOutput("s0_pass", obs(0, 3), 0);

      $display("[TB] stuck-at-1 DUT");
      mode_main = 2;
      applyStimulus(0, -1, cyc);
      checkOutput("s1_err", obs(0, 4), 16);
      checkOutput("s1_ff", obs(0, 5), 0);
      checkOutput("s1_ffv", obs(0, 6), 1);

      $display("[TB] inverted DUT, DWELL=1 SETTLE=0");
      mode_fast = 3;
      applyStimulus(1, -1, cyc);
      checkOutput("inv_latency", 32'(cyc), 32);
      checkOutput("inv_err", obs(1, 4), 32);
      checkOutput("inv_ff", obs(1, 5), 0);
      checkOutput("inv_pass", obs(1, 3), 0);

      $display("[TB] start re-pulsed at code 12");
      mode_main = 0;
      applyStimulus(0, 12, cyc);
      checkOutput("repulse_latency", 32'(cyc), 128);
      checkOutput("repulse_err", obs(0, 4), 0);
      checkOutput("repulse_pass", obs(0, 3), 1);

      $display("[TB] reset asserted at code 10");
      @(negedge clk);
      start_main = 1;
      @(posedge clk);
      #1;
      start_main = 0;
      for (int i = 0; i < 1000 && obs(0, 0) != 10; i++) begin
         @(posedge clk);
         #1;
      end
      checkOutput("reached_code10", obs(0, 0), 10);
      #2;
      rst_n = 0;
      #1;
      checkOutput("mid_rst_dut_in", obs(0, 0), 0);
      checkOutput("mid_rst_busy", obs(0, 1), 0);
      checkOutput("mid_rst_done", obs(0, 2), 0);
      checkOutput("mid_rst_pass", obs(0, 3), 0);
      checkOutput("mid_rst_err", obs(0, 4), 0);
      checkOutput("mid_rst_ff", obs(0, 5), 0);
      checkOutput("mid_rst_ffv", obs(0, 6), 0);
      @(negedge clk);
      rst_n = 1;
      applyStimulus(0, -1, cyc);
      checkOutput("fresh_latency", 32'(cyc), 128);
      checkOutput("fresh_err", obs(0, 4), 0);
      checkOutput("fresh_pass", obs(0, 3), 1);
      checkOutput("fresh_ffv", obs(0, 6), 0);

      // With SETTLE=0 a one-cycle-late DUT still shows the previous code's answer.
      $display("[TB] delayed DUT, SETTLE=0");
      exp_delay_errs = 0;
      prev = 5'd0;
      for (int k = 0; k < 32; k++) begin
         if (tbMaj(5'(k)) != tbMaj(prev)) exp_delay_errs++;
         prev = 5'(k);
      end
      mode_s0 = 4;
      applyStimulus(2, -1, cyc);
      checkOutput("dly0_latency", 32'(cyc), 128);
      checkOutput("dly0_err", obs(2, 4), 32'(exp_delay_errs));
      checkOutput("dly0_ff", obs(2, 5), 7);
      checkOutput("dly0_pass", obs(2, 3), 0);

      $display("[TB] delayed DUT, SETTLE=2");
      mode_main = 4;
      applyStimulus(0, -1, cyc);
      checkOutput("dly2_err", obs(0, 4), 0);
      checkOutput("dly2_pass", obs(0, 3), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
